// File: rtl/jtgng_ram_pkg.sv
// Shared types and helpers for the jtgng dual-port RAM with clear engine.
// Holds the clear FSM state encoding, the byte-lane width and the parity helper.
package jtgng_ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_st_t;

    // Bit that makes the byte plus itself hold an even number of ones
    function automatic logic even_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/jtgng_ram_clr_fsm.sv
// Clear engine: walks cnt over 0..wn-1 writing CLR_VAL, and muxes the
// RAM write port between the clear pass and the user write port.
module jtgng_ram_clr_fsm
    import jtgng_ram_pkg::*;
#(
    parameter int             dw      = 8,
    parameter int             aw      = 10,
    parameter int             wn      = 2**aw,
    parameter logic [dw-1:0]  CLR_VAL = '0
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clk_en,
    input  logic                 i_clr_req,
    input  logic                 i_we,
    input  logic [dw-1:0]        i_data,
    input  logic [dw/BYTE_W-1:0] i_be,
    input  logic [aw-1:0]        i_wr_addr,
    output logic                 o_busy,
    output logic                 o_mem_we,
    output logic [aw-1:0]        o_mem_addr,
    output logic [dw-1:0]        o_mem_data,
    output logic [dw/BYTE_W-1:0] o_mem_be
);

    localparam logic [aw-1:0] LAST = aw'(wn - 1);

    clr_st_t       r_state;
    clr_st_t       w_next;
    logic [aw-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_CLEAR;
        else          r_state <= w_next;
    end

    // Compare-before-wrap keeps cnt from aliasing when wn < 2**aw
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (r_state == ST_IDLE)
            r_cnt <= '0;
        else if (i_clk_en)
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_clr_req) w_next = ST_CLEAR;
            ST_CLEAR: if (i_clk_en && w_last) w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == ST_CLEAR);
        if (o_busy) begin
            o_mem_we   = i_clk_en;
            o_mem_addr = r_cnt;
            o_mem_data = CLR_VAL;
            o_mem_be   = '1;
        end else begin
            o_mem_we   = i_we & i_clk_en;
            o_mem_addr = i_wr_addr;
            o_mem_data = i_data;
            o_mem_be   = i_be;
        end
    end

endmodule

// File: rtl/jtgng_dual_ram_clr.sv
// Simple dual-port RAM with byte enables, RDW mode select and a clear engine.
// Define JTGNG_DUAL_RAM_PARITY_EN to store per-byte even parity and add par_err.
module jtgng_dual_ram_clr
    import jtgng_ram_pkg::*;
#(
    parameter int             dw      = 8,
    parameter int             aw      = 10,
    parameter int             wn      = 2**aw,
    parameter int             RDW_NEW = 0,
    parameter logic [dw-1:0]  CLR_VAL = '0,
    parameter                 simfile = "ram.hex"
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [dw-1:0]        data,
    input  logic [dw/BYTE_W-1:0] be,
    input  logic [aw-1:0]        wr_addr,
    input  logic                 we,
    input  logic [aw-1:0]        rd_addr,
    input  logic                 rd_en,
    input  logic                 clr_req,
    output logic                 busy,
    output logic [dw-1:0]        q,
`ifdef JTGNG_DUAL_RAM_PARITY_EN
    output logic                 par_err,
`endif
    output logic                 q_valid
);

    localparam int NB = dw / BYTE_W;

    logic [dw-1:0] r_mem [0:wn-1];
    logic [dw-1:0] r_q;
    logic          r_q_valid;

    logic          w_busy;
    logic          w_mwe;
    logic [aw-1:0] w_maddr;
    logic [dw-1:0] w_mdata;
    logic [NB-1:0] w_mbe;
    logic          w_rd_ok;
    logic          w_hit;
    logic [dw-1:0] w_rd_mem;
    logic [dw-1:0] w_merged;
    logic          w_unused_simfile;

    // The preload file is only meaningful to simulation flows
    assign w_unused_simfile = ^simfile;

    jtgng_ram_clr_fsm #(
        .dw      (dw),
        .aw      (aw),
        .wn      (wn),
        .CLR_VAL (CLR_VAL)
    ) u_fsm (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clk_en   (clk_en),
        .i_clr_req  (clr_req),
        .i_we       (we),
        .i_data     (data),
        .i_be       (be),
        .i_wr_addr  (wr_addr),
        .o_busy     (w_busy),
        .o_mem_we   (w_mwe),
        .o_mem_addr (w_maddr),
        .o_mem_data (w_mdata),
        .o_mem_be   (w_mbe)
    );

    always_ff @(posedge clk) begin
        if (w_mwe) begin
            for (int i = 0; i < NB; i++) begin
                if (w_mbe[i])
                    r_mem[w_maddr][i*BYTE_W +: BYTE_W] <= w_mdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_rd_ok  = rd_en & ~w_busy;
    assign w_rd_mem = r_mem[rd_addr];
    assign w_hit    = (RDW_NEW != 0) && w_mwe && !w_busy && (w_maddr == rd_addr);

    always_comb begin
        w_merged = w_rd_mem;
        for (int i = 0; i < NB; i++) begin
            if (be[i])
                w_merged[i*BYTE_W +: BYTE_W] = data[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= w_rd_ok;
            if (w_rd_ok)
                r_q <= w_hit ? w_merged : w_rd_mem;
        end
    end

    assign busy    = w_busy;
    assign q       = r_q;
    assign q_valid = r_q_valid;

`ifdef JTGNG_DUAL_RAM_PARITY_EN
    logic [NB-1:0] r_par [0:wn-1];
    logic [NB-1:0] w_wpar;
    logic [NB-1:0] w_rbad;
    logic          r_par_err;

    always_comb begin
        w_wpar = '0;
        w_rbad = '0;
        for (int i = 0; i < NB; i++) begin
            w_wpar[i] = even_par(w_mdata[i*BYTE_W +: BYTE_W]);
            w_rbad[i] = even_par(w_rd_mem[i*BYTE_W +: BYTE_W]) ^ r_par[rd_addr][i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_mwe) begin
            for (int i = 0; i < NB; i++) begin
                if (w_mbe[i])
                    r_par[w_maddr][i] <= w_wpar[i];
            end
        end
    end

    // Bypassed data carries freshly computed parity, so it is never flagged
    always_ff @(posedge clk) begin
        if (!rst_n) r_par_err <= 1'b0;
        else        r_par_err <= w_rd_ok & ~w_hit & (|w_rbad);
    end

    assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_jtgng_dual_ram_clr.sv
// Self-checking bench: two RAMs (old-data and bypass RDW) share one stimulus
// and are compared every cycle against a word-array reference model.
module tb_jtgng_dual_ram_clr;

    localparam int            DW  = 16;
    localparam int            AW  = 4;
    localparam int            WN  = 16;
    localparam logic [DW-1:0] CLR = 16'h5A5A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic [DW-1:0] data = '0;
    logic [1:0]    be = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          we = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic          clr_req = 1'b0;

    logic          busy0, busy1, qv0, qv1;
    logic [DW-1:0] q0, q1;
`ifdef JTGNG_DUAL_RAM_PARITY_EN
    logic          pe0, pe1;
    bit            par_flip = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    jtgng_dual_ram_clr #(
        .dw(DW), .aw(AW), .wn(WN), .RDW_NEW(0), .CLR_VAL(CLR)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data(data), .be(be),
        .wr_addr(wr_addr), .we(we), .rd_addr(rd_addr), .rd_en(rd_en),
        .clr_req(clr_req), .busy(busy0), .q(q0),
`ifdef JTGNG_DUAL_RAM_PARITY_EN
        .par_err(pe0),
`endif
        .q_valid(qv0)
    );

    jtgng_dual_ram_clr #(
        .dw(DW), .aw(AW), .wn(WN), .RDW_NEW(1), .CLR_VAL(CLR)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data(data), .be(be),
        .wr_addr(wr_addr), .we(we), .rd_addr(rd_addr), .rd_en(rd_en),
        .clr_req(clr_req), .busy(busy1), .q(q1),
`ifdef JTGNG_DUAL_RAM_PARITY_EN
        .par_err(pe1),
`endif
        .q_valid(qv1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: word array, clear pointer and busy flag
    logic [DW-1:0] m_mem [WN];
    bit            m_busy = 1'b1;
    int            m_ptr = 0;
    logic [DW-1:0] m_q0 = '0, m_q1 = '0;
    bit            m_qv = 1'b0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        bit            b, wa;
        logic [DW-1:0] old, mg;
        if (!rst_n) begin
            m_busy = 1'b1; m_ptr = 0; m_q0 = '0; m_q1 = '0; m_qv = 1'b0;
        end else begin
            b   = m_busy;
            wa  = !b && we && clk_en;
            old = m_mem[rd_addr];
            mg  = old;
            for (int i = 0; i < 2; i++)
                if (be[i]) mg[i*8 +: 8] = data[i*8 +: 8];
            if (rd_en && !b) begin
                m_qv = 1'b1;
                m_q0 = old;
                m_q1 = (wa && wr_addr == rd_addr) ? mg : old;
            end else begin
                m_qv = 1'b0;
            end
            if (wa)
                for (int i = 0; i < 2; i++)
                    if (be[i]) m_mem[wr_addr][i*8 +: 8] = data[i*8 +: 8];
            if (b && clk_en) begin
                m_mem[m_ptr] = CLR;
                if (m_ptr == WN - 1) m_busy = 1'b0;
                else m_ptr++;
            end else if (!b && clr_req) begin
                m_busy = 1'b1; m_ptr = 0;
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy0", 32'(busy0), 32'(m_busy));
            chk("busy1", 32'(busy1), 32'(m_busy));
            chk("qv0", 32'(qv0), 32'(m_qv));
            chk("qv1", 32'(qv1), 32'(m_qv));
            chk("q0", 32'(q0), 32'(m_q0));
            chk("q1", 32'(q1), 32'(m_q1));
`ifdef JTGNG_DUAL_RAM_PARITY_EN
            if (!par_flip) chk("par_err0", 32'(pe0), 32'd0);
            chk("par_err1", 32'(pe1), 32'd0);
`endif
        end
    end

    task automatic rd(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        we = 1'b1; wr_addr = a; data = d; be = b;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Counts cycles with busy high, poking stalls, clr_req, a write and a read
    task automatic count_busy(input int st, input int sl, input int rq,
                              input int wa, output int n);
        int i;
        n = 0;
        for (i = 0; i < 300; i++) begin
            if (!busy0) break;
            n++;
            clk_en  = !(i >= st && i < st + sl);
            clr_req = (i == rq);
            we      = (i == wa); wr_addr = 4'd9; data = 16'hBEEF; be = 2'b11;
            rd_en   = (i == 5);  rd_addr = 4'd3;
            @(negedge clk);
        end
        clk_en = 1'b1; clr_req = 1'b0; we = 1'b0; rd_en = 1'b0;
        if (i == 300) begin
            checks++; fails++;
            $display("FAIL busy_timeout actual=stuck required=release");
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_busy(-1, 0, -1, -1, n);
        chk("clr_len_reset", 32'(n), 32'd16);
        for (int a = 0; a < WN; a++) begin
            rd(AW'(a));
            chk("clr_rd_q", 32'(q0), 32'h5A5A);
            chk("clr_rd_v", 32'(qv0), 32'd1);
        end

        wr(4'd3, 16'hAAAA, 2'b11);
        wr(4'd3, 16'h1234, 2'b01);
        rd(4'd3);
        chk("be_q0", 32'(q0), 32'hAA34);
        chk("be_q1", 32'(q1), 32'hAA34);

        wr(4'd5, 16'h0011, 2'b11);
        we = 1'b1; wr_addr = 4'd5; data = 16'h0022; be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd5;
        @(negedge clk);
        we = 1'b0; rd_en = 1'b0;
        chk("rdw_old", 32'(q0), 32'h0011);
        chk("rdw_new", 32'(q1), 32'h0022);
        rd(4'd5);
        chk("rdw_after", 32'(q0), 32'h0022);

        clk_en = 1'b0;
        wr(4'd7, 16'hFFFF, 2'b11);
        rd(4'd3);
        chk("rd_noen_q", 32'(q0), 32'hAA34);
        chk("rd_noen_v", 32'(qv0), 32'd1);
        clk_en = 1'b1;
        rd(4'd7);
        chk("we_noen", 32'(q0), 32'h5A5A);

        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        count_busy(-1, 0, 4, 2, n);
        chk("clr_len_req", 32'(n), 32'd16);
        rd(4'd9);
        chk("busy_wr_drop", 32'(q0), 32'h5A5A);
        rd(4'd3);
        chk("reclear", 32'(q1), 32'h5A5A);

        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        count_busy(3, 5, -1, -1, n);
        chk("clr_len_stall", 32'(n), 32'd21);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(-1, 0, -1, -1, n);
        chk("clr_len_rst", 32'(n), 32'd16);

`ifdef JTGNG_DUAL_RAM_PARITY_EN
        par_flip = 1'b1;
        dut0.r_par[2][0] = ~dut0.r_par[2][0];
        rd(4'd2);
        chk("par_bad", 32'(pe0), 32'd1);
        chk("par_bad_v", 32'(qv0), 32'd1);
        rd(4'd4);
        chk("par_good", 32'(pe0), 32'd0);
        wr(4'd2, 16'h5A5A, 2'b11);
        par_flip = 1'b0;
`endif

        repeat (800) begin
            rst_n   = ($urandom_range(0, 255) != 0);
            clk_en  = ($urandom_range(0, 7) != 0);
            we      = 1'($urandom);
            rd_en   = 1'($urandom);
            be      = 2'($urandom);
            data    = 16'($urandom);
            clr_req = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1) begin
                wr_addr = AW'($urandom_range(0, 3));
                rd_addr = AW'($urandom_range(0, 3));
            end else begin
                wr_addr = AW'($urandom);
                rd_addr = AW'($urandom);
            end
            @(negedge clk);
        end
        rst_n = 1'b1; clk_en = 1'b1; we = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
